// File: rtl/xorshift_pkg.sv
// xorshift_pkg: shared constants, lane state bundle and step math
// for the multi-lane xorshift128/xorshift128+ generator.
package xorshift_pkg;

  localparam int LANE_W = 64;

  localparam int SH_A = 23;
  localparam int SH_B = 18;
  localparam int SH_C = 5;

  localparam logic [LANE_W-1:0] ZERO_SEED = 64'h9E3779B97F4A7C15;

  localparam bit MODE_PLAIN = 1'b0;
  localparam bit MODE_PLUS  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARM,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [LANE_W-1:0] s0;
    logic [LANE_W-1:0] s1;
  } lane_t;

  function automatic lane_t xs_step(input lane_t s);
    lane_t r;
    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
    a = s.s0;
    b = s.s1;
    a = a ^ (a << SH_A);
    r.s0 = b;
    r.s1 = a ^ b ^ (a >> SH_B) ^ (b >> SH_C);
    return r;
  endfunction

  // An all-zero state is a fixed point of xorshift, so it is
  // never allowed to enter the state registers.
  function automatic lane_t xs_seed(
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b
  );
    lane_t r;
    if ((a == '0) && (b == '0)) begin
      r.s0 = ZERO_SEED;
      r.s1 = '0;
    end else begin
      r.s0 = a;
      r.s1 = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/xorshift128p_lane.sv
// xorshift128p_lane: one 64-bit lane (state regs, step, seed load).
// Ports: clk, rst_n, load, step, seed1, seed2 -> value.
module xorshift128p_lane
  import xorshift_pkg::*;
#(
  parameter bit MODE = MODE_PLUS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LANE_W-1:0] seed1,
  input  logic [LANE_W-1:0] seed2,
  output logic [LANE_W-1:0] value
);

  lane_t st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
    end else if (load) begin
      st <= xs_seed(seed1, seed2);
    end else if (step) begin
      st <= xs_step(st);
    end
  end

  if (MODE == MODE_PLUS) begin : g_plus
    assign value = st.s0 + st.s1;
  end else begin : g_plain
    assign value = st.s1;
  end

endmodule

// File: rtl/xorshift_array.sv
// xorshift_array: LANES lock-step xorshift lanes with warm-up and
// valid/ready output. Ports: clk, rst_n, seed1, seed2, set,
// out_data, out_valid, out_ready.
module xorshift_array
  import xorshift_pkg::*;
#(
  parameter int LANES  = 4,
  parameter bit MODE   = MODE_PLUS,
  parameter int WARMUP = 8,
  localparam int OUT_W = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] seed1,
  input  logic [OUT_W-1:0] seed2,
  input  logic             set,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW =
    (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam state_t LOAD_ST =
    (WARMUP == 0) ? ST_RUN : ST_WARM;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          step;
  logic [OUT_W-1:0] cat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // set overrides any step; a RUN handshake in the same
  // cycle is still a delivered word.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    step      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        state_n = ST_IDLE;
      end
      ST_WARM: begin
        step  = 1'b1;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        out_valid = 1'b1;
        step      = out_ready;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (set) begin
      state_n = LOAD_ST;
      cnt_n   = '0;
      step    = 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] v;

    xorshift128p_lane #(
      .MODE(MODE)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (set),
      .step (step),
      .seed1(seed1[i*LANE_W +: LANE_W]),
      .seed2(seed2[i*LANE_W +: LANE_W]),
      .value(v)
    );

    // Lane 0 lands in the MSBs of the output word.
    assign cat[OUT_W-1-i*LANE_W -: LANE_W] = v;
  end

  assign out_data = out_valid ? cat : '0;

endmodule

// File: tb/tb_xorshift_array.sv
// tb_xorshift_array: scoreboard bench for xorshift_array.
// Three instances: 1-lane plus, 1-lane plain, 4-lane plus warm-up 2.
module tb_xorshift_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [63:0]  s1a, s2a, da;
  logic         seta, rdya, va;
  logic [63:0]  s1b, s2b, db;
  logic         setb, rdyb, vb;
  logic [255:0] s1c, s2c, dc;
  logic         setc, rdyc, vc;

  logic [63:0]  qa[$];
  logic [63:0]  qb[$];
  logic [255:0] qc[$];

  int vecs = 0;
  int errs = 0;

  localparam logic [255:0] NS1 =
    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_1122334455667788;
  localparam logic [255:0] NS2 =
    256'hDEADBEEFCAFEF00D_0000000000000000_A5A5A5A55A5A5A5A_0000000000000001;

  always #5 clk = ~clk;

  xorshift_array #(
    .LANES(1), .MODE(1'b1), .WARMUP(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .seed1(s1a), .seed2(s2a),
    .set(seta), .out_data(da), .out_valid(va), .out_ready(rdya)
  );

  xorshift_array #(
    .LANES(1), .MODE(1'b0), .WARMUP(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .seed1(s1b), .seed2(s2b),
    .set(setb), .out_data(db), .out_valid(vb), .out_ready(rdyb)
  );

  xorshift_array #(
    .LANES(4), .MODE(1'b1), .WARMUP(2)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .seed1(s1c), .seed2(s2c),
    .set(setc), .out_data(dc), .out_valid(vc), .out_ready(rdyc)
  );

  function automatic logic [127:0] m_step(input logic [127:0] s);
    logic [63:0] x, y, t;
    x = s[127:64];
    y = s[63:0];
    t = x ^ (x << 23);
    return {y, t ^ y ^ (t >> 18) ^ (y >> 5)};
  endfunction

  function automatic logic [63:0] m_out(
    input logic [127:0] s, input bit plus);
    return plus ? s[127:64] + s[63:0] : s[63:0];
  endfunction

  function automatic logic [127:0] m_seed(
    input logic [63:0] a, input logic [63:0] b);
    if (a == 64'd0 && b == 64'd0)
      return {64'h9E3779B97F4A7C15, 64'd0};
    return {a, b};
  endfunction

  function automatic logic [63:0] m_nth(
    input logic [63:0] a, input logic [63:0] b,
    input bit plus, input int k);
    logic [127:0] st;
    st = m_seed(a, b);
    for (int i = 0; i < k; i++) st = m_step(st);
    return m_out(st, plus);
  endfunction

  task automatic push_c(input logic [255:0] a, input logic [255:0] b,
                        input int warm, input int n);
    logic [127:0] st[4];
    logic [255:0] w;
    for (int l = 0; l < 4; l++) st[l] = m_seed(a[l*64 +: 64], b[l*64 +: 64]);
    for (int k = 0; k < warm; k++)
      for (int l = 0; l < 4; l++) st[l] = m_step(st[l]);
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < 4; l++) w[255-l*64 -: 64] = m_out(st[l], 1'b1);
      qc.push_back(w);
      for (int l = 0; l < 4; l++) st[l] = m_step(st[l]);
    end
  endtask

  task automatic test_reset();
    seta = 0; setb = 0; setc = 0;
    rdya = 0; rdyb = 0; rdyc = 0;
    s1a = '0; s2a = '0; s1b = '0; s2b = '0; s1c = '0; s2c = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (va !== 1'b0 || da !== 64'd0) begin
      errs++;
      $display("FAIL reset_a valid=%b data=%h exp 0/0", va, da);
    end
    vecs++;
    if (vb !== 1'b0 || db !== 64'd0) begin
      errs++;
      $display("FAIL reset_b valid=%b data=%h exp 0/0", vb, db);
    end
    vecs++;
    if (vc !== 1'b0 || dc !== 256'd0) begin
      errs++;
      $display("FAIL reset_c valid=%b data=%h exp 0/0", vc, dc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    rdya = 1; rdyb = 1; rdyc = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (vc !== 1'b0 || dc !== 256'd0) begin
      errs++;
      $display("FAIL idle_c valid=%b data=%h exp 0/0", vc, dc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_plus();
    logic [63:0] e;
    s1a = 64'd1; s2a = 64'd2; seta = 1; rdya = 1;
    qa.delete();
    qa.push_back(64'd3);
    qa.push_back(64'h800025);
    for (int k = 2; k < 6; k++) qa.push_back(m_nth(1, 2, 1'b1, k));
    @(posedge clk); #1 seta = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vecs++;
      if (va !== 1'b1 || qa.size() == 0) begin
        errs++;
        $display("FAIL plus_valid[%0d] valid=%b exp 1", i, va);
      end else begin
        e = qa.pop_front();
        if (da !== e) begin
          errs++;
          $display("FAIL plus_data[%0d] got=%h exp=%h", i, da, e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_seed();
    logic [63:0] e;
    s1a = 64'd0; s2a = 64'd0; seta = 1; rdya = 1;
    qa.delete();
    qa.push_back(64'h9E3779B97F4A7C15);
    for (int k = 1; k < 3; k++) qa.push_back(m_nth(0, 0, 1'b1, k));
    @(posedge clk); #1 seta = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (va !== 1'b1 || qa.size() == 0) begin
        errs++;
        $display("FAIL zseed_valid[%0d] valid=%b exp 1", i, va);
      end else begin
        e = qa.pop_front();
        if (da !== e) begin
          errs++;
          $display("FAIL zseed_data[%0d] got=%h exp=%h", i, da, e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_plain();
    logic [63:0] e;
    s1b = 64'd1; s2b = 64'd2; setb = 1; rdyb = 1;
    qb.delete();
    qb.push_back(64'd2);
    qb.push_back(64'h800023);
    for (int k = 2; k < 5; k++) qb.push_back(m_nth(1, 2, 1'b0, k));
    @(posedge clk); #1 setb = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (vb !== 1'b1 || qb.size() == 0) begin
        errs++;
        $display("FAIL plain_valid[%0d] valid=%b exp 1", i, vb);
      end else begin
        e = qb.pop_front();
        if (db !== e) begin
          errs++;
          $display("FAIL plain_data[%0d] got=%h exp=%h", i, db, e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_warmup();
    logic [255:0] e;
    s1c = {64'd1, 64'd0, 64'd1, 64'd1};
    s2c = {64'd2, 64'd0, 64'd2, 64'd2};
    setc = 1; rdyc = 1;
    qc.delete();
    push_c(s1c, s2c, 2, 16);
    @(posedge clk); #1 setc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (i < 2) begin
        if (vc !== 1'b0) begin
          errs++;
          $display("FAIL warm_valid[%0d] valid=%b exp 0", i, vc);
        end
      end else if (vc !== 1'b1 || qc.size() == 0) begin
        errs++;
        $display("FAIL warm_rise[%0d] valid=%b exp 1", i, vc);
      end else begin
        e = qc.pop_front();
        if (dc !== e) begin
          errs++;
          $display("FAIL warm_data[%0d] got=%h exp=%h", i, dc, e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [255:0] e;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      vecs++;
      if (vc !== 1'b1 || qc.size() == 0) begin
        errs++;
        $display("FAIL bp_valid[%0d] valid=%b exp 1", i, vc);
      end else if (!rdyc) begin
        if (dc !== qc[0]) begin
          errs++;
          $display("FAIL bp_hold[%0d] got=%h exp=%h", i, dc, qc[0]);
        end
      end else begin
        e = qc.pop_front();
        if (dc !== e) begin
          errs++;
          $display("FAIL bp_data[%0d] got=%h exp=%h", i, dc, e);
        end
      end
      @(posedge clk); #1;
      rdyc = (i >= 1 && i < 6) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_set_in_run();
    logic [255:0] e;
    rdyc = 1;
    setc = 1; s1c = NS1; s2c = NS2;
    @(negedge clk);
    vecs++;
    if (vc !== 1'b1 || qc.size() == 0) begin
      errs++;
      $display("FAIL setrun_valid valid=%b exp 1", vc);
    end else begin
      e = qc.pop_front();
      if (dc !== e) begin
        errs++;
        $display("FAIL setrun_data got=%h exp=%h", dc, e);
      end
    end
    @(posedge clk); #1 setc = 0;
    @(negedge clk);
    vecs++;
    if (vc !== 1'b0) begin
      errs++;
      $display("FAIL setrun_warm valid=%b exp 0", vc);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (vc !== 1'b0 || dc !== 256'd0) begin
      errs++;
      $display("FAIL rst_warm valid=%b data=%h exp 0/0", vc, dc);
    end
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vecs++;
      if (vc !== 1'b0 || dc !== 256'd0) begin
        errs++;
        $display("FAIL post_rst[%0d] valid=%b data=%h exp 0/0", i, vc, dc);
      end
    end
    @(posedge clk); #1;
    setc = 1;
    qc.delete();
    push_c(NS1, NS2, 2, 6);
    @(posedge clk); #1 setc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vecs++;
      if (i < 2) begin
        if (vc !== 1'b0) begin
          errs++;
          $display("FAIL restart_warm[%0d] valid=%b exp 0", i, vc);
        end
      end else if (vc !== 1'b1 || qc.size() == 0) begin
        errs++;
        $display("FAIL restart_valid[%0d] valid=%b exp 1", i, vc);
      end else begin
        e = qc.pop_front();
        if (dc !== e) begin
          errs++;
          $display("FAIL restart_data[%0d] got=%h exp=%h", i, dc, e);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    vecs++;
    if (vc !== 1'b1) begin
      errs++;
      $display("FAIL prerst_valid valid=%b exp 1", vc);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (vc !== 1'b0 || dc !== 256'd0) begin
      errs++;
      $display("FAIL rst_run valid=%b data=%h exp 0/0", vc, dc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (vc !== 1'b0 || va !== 1'b0 || vb !== 1'b0) begin
      errs++;
      $display("FAIL rst_hold valid=%b%b%b exp 000", va, vb, vc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", vecs);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_plus();
    test_zero_seed();
    test_plain();
    test_warmup();
    test_backpressure();
    test_set_in_run();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/xorshift_array.md
# xorshift_array

Parametrised multi-lane xorshift128/xorshift128+ pseudo-random generator for the elliptic-curve datapath, replacing the fixed four-lane 256-bit generator. LANES independent 64-bit lanes are seeded together and concatenated into one LANES*64-bit word. Adds a warm-up discard phase, zero-seed protection and a valid/ready output handshake.

## Interface
- LANES, 4: number of 64-bit lanes; output width OUT_W = LANES*64.
- MODE, 1: 1 = xorshift128+ (sum output), 0 = plain xorshift128 (state output).
- WARMUP, 8: state steps discarded after every seed load; 0 allowed.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed1  input  OUT_W  first seed word; lane i uses bits [64i+63:64i].
- seed2  input  OUT_W  second seed word; same lane slicing.
- set  input  1  load seeds this cycle; single-cycle pulse or level.
- out_data  output  OUT_W  random word; lane 0 at [OUT_W-1:OUT_W-64], lane LANES-1 at [63:0].
- out_valid  output  1  out_data holds a fresh value.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- Per lane state (s0, s1), 64 bits each. One step: a = s0; b = s1; s0' = b; a ^= a<<23; s1' = a ^ b ^ (a>>18) ^ (b>>5).
- Lane output before step: MODE=1 -> s0 + s1 (mod 2^64); MODE=0 -> s1.
- Seed load: s0 <= seed1 lane slice, s1 <= seed2 lane slice; if both slices zero, s0 <= ZERO_SEED (64'h9E3779B97F4A7C15), s1 <= 0.
- FSM: IDLE (unseeded), WARM, RUN.
  - IDLE: out_valid=0, out_data forced 0; set -> WARM (or RUN if WARMUP=0).
  - WARM: every cycle all lanes step, counter++; after WARMUP steps -> RUN; out_valid=0.
  - RUN: out_valid=1; lanes step only on out_valid && out_ready; otherwise state and out_data hold.
- set in any state reloads seeds, clears counter, next state WARM (RUN if WARMUP=0). set wins over a step in the same cycle; a coincident out_valid && out_ready transfer is still counted as delivered.
- All lanes step in lock-step; no per-lane enables.

## Timing
- Reset: all state 0, counter 0, FSM IDLE, out_valid 0, out_data 0.
- set at edge N: seeded state visible after N; WARMUP=0 -> out_valid=1 in cycle N+1 with first output of seeded state; WARMUP=k -> out_valid rises in cycle N+1+k, first value is output of k-th stepped state.
- RUN throughput: one word per cycle with out_ready held high.
- out_data derived from state registers through the 64-bit adder only; stable while out_valid && !out_ready.
- rst_n assert mid-WARM or mid-RUN: immediate return to reset values; no output until next set.
- Counter width $clog2(WARMUP+1), saturating not required (cleared on set).

## Structure
- Package xorshift_pkg: LANE_W=64, shift constants 23/18/5, ZERO_SEED, FSM state enum, mode constants.
- Sub-module xorshift128p_lane: one lane's state registers, step logic, zero-seed substitution and MODE output mux; inputs step/load, seeds; output 64-bit value.
- Top: generate loop over LANES, shared FSM and warm-up counter, output concatenation.

## Test plan
- LANES=1, MODE=1, WARMUP=0, seed1=1, seed2=2, set, out_ready=1 -> outputs 3, then 64'h800025.
- Same seeds, MODE=0 -> outputs 2, then 64'h800023.
- WARMUP=2, seeds 1/2, MODE=1 -> out_valid low 2 cycles after load, rises in cycle N+3; first word equals third value of the WARMUP=0 sequence.
- LANES=4, lane 2 seeds zero, others 1/2 -> lane 2 first output 64'h9E3779B97F4A7C15, others 3; lane 0 in MSBs.
- Backpressure: out_ready low 5 cycles in RUN -> out_data constant, out_valid held 1; on release sequence resumes without skip.
- set during RUN with simultaneous handshake, then rst_n pulse mid-WARM -> sequence restarts from new seeds; after reset out_valid=0, out_data=0 until next set.
